// File: rtl/pokey_sio_link.sv
// Device-side POKEY SEROUT/SERIN serial link: async 8N1 transmitter and receiver.
// Optional POKEY_SIO_LOOPBACK_EN adds loop_i to route the TX bit into the RX path.
module pokey_sio_link #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
`ifdef POKEY_SIO_LOOPBACK_EN
  input  logic       loop_i,
`endif
  input  logic [7:0] serout_i,
  input  logic       serout_rdy_i,
  output logic       serout_ack_o,
  output logic [7:0] serin_o,
  output logic       serin_rdy_o,
  input  logic       serin_ack_i,
  output logic       txd_o,
  input  logic       rxd_i,
  output logic       tx_busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic        txd_q, txd_n;

  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [1:0]  rx_sync;
  logic        rx_s, rx_src;
  logic [7:0]  serin_q, serin_n;
  logic        rdy_q, rdy_n;
  logic        ferr_q, ferr_n;
  logic        ovr_q, ovr_n;

  // Ack and busy span exactly the non-IDLE states, so both derive from the state.
  assign serout_ack_o = (tx_state != TX_IDLE);
  assign tx_busy_o    = (tx_state != TX_IDLE);
  assign serin_o      = serin_q;
  assign serin_rdy_o  = rdy_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign rx_s         = rx_sync[1];

`ifdef POKEY_SIO_LOOPBACK_EN
  assign rx_src = loop_i ? txd_q : rxd_i;
  assign txd_o  = loop_i ? 1'b1 : txd_q;
`else
  assign rx_src = rxd_i;
  assign txd_o  = txd_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_bit   <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_sh    <= tx_sh_n;
      tx_bit   <= tx_bit_n;
      txd_q    <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_sh_n    = tx_sh;
    tx_bit_n   = tx_bit;
    txd_n      = txd_q;
    case (tx_state)
      TX_IDLE: begin
        if (serout_rdy_i) begin
          tx_sh_n    = serout_i;
          txd_n      = 1'b0;
          tx_cnt_n   = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = tx_sh[0];
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_sh_n  = {1'b0, tx_sh[7:1]};
            txd_n    = tx_sh[1];
            tx_bit_n = tx_bit + 3'd1;
          end
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_sync  <= '1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_bit   <= '0;
      serin_q  <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx_src};
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_sh    <= rx_sh_n;
      rx_bit   <= rx_bit_n;
      serin_q  <= serin_n;
      rdy_q    <= rdy_n;
      ferr_q   <= ferr_n;
      ovr_q    <= ovr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_sh_n    = rx_sh;
    rx_bit_n   = rx_bit;
    serin_n    = serin_q;
    rdy_n      = rdy_q & ~serin_ack_i;
    ferr_n     = 1'b0;
    ovr_n      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          if (rx_s) begin
            // Overrun judged on the pre-clear flag even if an ack lands on this edge.
            if (rdy_q) begin
              ovr_n = 1'b1;
            end else begin
              serin_n = rx_sh;
              rdy_n   = 1'b1;
            end
            rx_state_n = RX_IDLE;
          end else begin
            ferr_n     = 1'b1;
            rx_state_n = RX_BREAK;
          end
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_BREAK: begin
        if (rx_s) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pokey_sio_link.sv
// Directed bench for pokey_sio_link at CLKS_PER_BIT=16; loopback vectors build with POKEY_SIO_LOOPBACK_EN.
module tb_pokey_sio_link;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] serout;
  logic       serout_rdy;
  logic       serout_ack;
  logic [7:0] serin;
  logic       serin_rdy;
  logic       serin_ack;
  logic       txd;
  logic       rxd;
  logic       tx_busy;
  logic       frame_err;
  logic       overrun;
`ifdef POKEY_SIO_LOOPBACK_EN
  logic       loop_en;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned ovr_cnt = 0;
  int unsigned ferr_cnt = 0;
  int unsigned txd_low = 0;

  always #5 clk = ~clk;

  pokey_sio_link #(.CLKS_PER_BIT(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
`ifdef POKEY_SIO_LOOPBACK_EN
    .loop_i       (loop_en),
`endif
    .serout_i     (serout),
    .serout_rdy_i (serout_rdy),
    .serout_ack_o (serout_ack),
    .serin_o      (serin),
    .serin_rdy_o  (serin_rdy),
    .serin_ack_i  (serin_ack),
    .txd_o        (txd),
    .rxd_i        (rxd),
    .tx_busy_o    (tx_busy),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (overrun) ovr_cnt++;
    if (frame_err) ferr_cnt++;
    if (!txd) txd_low++;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int unsigned t);
    while (cyc < t) tick();
  endtask

  // Start bit plus 8 data bits; the caller chooses the stop level.
  task automatic rx_frame(input logic [7:0] b);
    rxd = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      ticks(16);
    end
  endtask

  task automatic wait_rdy(input int unsigned limit);
    int unsigned lim;
    lim = cyc + limit;
    while (!serin_rdy && cyc < lim) tick();
  endtask

  initial begin
    int unsigned e0;
    int unsigned c0;
    logic [9:0]  frame;
    rst = 1'b1;
    serout = 8'h00;
    serout_rdy = 1'b0;
    serin_ack = 1'b0;
    rxd = 1'b1;
`ifdef POKEY_SIO_LOOPBACK_EN
    loop_en = 1'b0;
`endif
    ticks(3);
    check("rst_txd", {31'b0, txd}, 1);
    check("rst_ack", {31'b0, serout_ack}, 0);
    check("rst_serin", {24'b0, serin}, 8'h00);
    check("rst_rdy", {31'b0, serin_rdy}, 0);
    check("rst_busy", {31'b0, tx_busy}, 0);
    check("rst_ferr", {31'b0, frame_err}, 0);
    check("rst_ovr", {31'b0, overrun}, 0);
    rst = 1'b0;
    ticks(2);

    // TX of 8'hA5: frame LSB-first is 0,1,0,1,0,0,1,0,1,1
    serout = 8'hA5;
    serout_rdy = 1'b1;
    tick();
    e0 = cyc;
    serout_rdy = 1'b0;
    serout = 8'hFF;
    check("tx_ack_rise", {31'b0, serout_ack}, 1);
    check("tx_busy_rise", {31'b0, tx_busy}, 1);
    check("tx_start_now", {31'b0, txd}, 0);
    frame = 10'b1_1010_0101_0;
    for (int unsigned k = 0; k < 10; k++) begin
      run_to(e0 + 16 * k + 8);
      check($sformatf("tx_bit%0d", k), {31'b0, txd}, {31'b0, frame[k]});
    end
    run_to(e0 + 159);
    check("tx_ack_159", {31'b0, serout_ack}, 1);
    tick();
    check("tx_ack_160", {31'b0, serout_ack}, 0);
    check("tx_busy_160", {31'b0, tx_busy}, 0);
    check("tx_idle_txd", {31'b0, txd}, 1);

    // Back-to-back: rdy held high, next byte latched on the edge after STOP ends
    serout = 8'h0F;
    serout_rdy = 1'b1;
    tick();
    e0 = cyc;
    run_to(e0 + 160);
    check("b2b_ack_gap", {31'b0, serout_ack}, 0);
    serout = 8'h80;
    tick();
    check("b2b_ack_again", {31'b0, serout_ack}, 1);
    check("b2b_start", {31'b0, txd}, 0);
    serout_rdy = 1'b0;
    run_to(e0 + 161 + 16 + 8);
    check("b2b_bit0", {31'b0, txd}, 0);
    run_to(e0 + 161 + 160 + 2);
    check("b2b_done", {31'b0, tx_busy}, 0);

    // RX 8'h3C with latency measured from the start-bit edge
    c0 = cyc;
    rx_frame(8'h3C);
    rxd = 1'b1;
    check("rx_rdy_early", {31'b0, serin_rdy}, 0);
    wait_rdy(40);
    check("rx_lat", cyc - c0, 155);
    check("rx_data", {24'b0, serin}, 8'h3C);
    ticks(10);
    check("rx_rdy_hold", {31'b0, serin_rdy}, 1);

    // 8'h55 while 8'h3C unacked: one overrun pulse, SERIN unchanged
    ovr_cnt = 0;
    ferr_cnt = 0;
    rx_frame(8'h55);
    rxd = 1'b1;
    ticks(30);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_ferr", ferr_cnt, 0);
    check("ovr_serin", {24'b0, serin}, 8'h3C);
    check("ovr_rdy", {31'b0, serin_rdy}, 1);
    serin_ack = 1'b1;
    tick();
    serin_ack = 1'b0;
    check("ack_clear", {31'b0, serin_rdy}, 0);

    // Framing error: 8'h12 with stop low, line held low 40 cycles
    ovr_cnt = 0;
    ferr_cnt = 0;
    rx_frame(8'h12);
    rxd = 1'b0;
    ticks(40);
    rxd = 1'b1;
    ticks(20);
    check("ferr_pulses", ferr_cnt, 1);
    check("ferr_ovr", ovr_cnt, 0);
    check("ferr_rdy", {31'b0, serin_rdy}, 0);
    check("ferr_serin", {24'b0, serin}, 8'h3C);
    c0 = cyc;
    rx_frame(8'h34);
    rxd = 1'b1;
    wait_rdy(40);
    check("rx2_lat", cyc - c0, 155);
    check("rx2_data", {24'b0, serin}, 8'h34);
    ticks(10);
    serin_ack = 1'b1;
    tick();
    serin_ack = 1'b0;
    check("ack2_clear", {31'b0, serin_rdy}, 0);

    // Glitch shorter than half a bit is rejected as a false start
    ovr_cnt = 0;
    ferr_cnt = 0;
    rxd = 1'b0;
    ticks(4);
    rxd = 1'b1;
    ticks(200);
    check("glitch_rdy", {31'b0, serin_rdy}, 0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_ovr", ovr_cnt, 0);
    check("glitch_serin", {24'b0, serin}, 8'h34);

    // Async reset in the middle of a TX frame of 8'h00
    serout = 8'h00;
    serout_rdy = 1'b1;
    tick();
    serout_rdy = 1'b0;
    ticks(40);
    check("mid_txd_low", {31'b0, txd}, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_txd", {31'b0, txd}, 1);
    check("arst_ack", {31'b0, serout_ack}, 0);
    check("arst_busy", {31'b0, tx_busy}, 0);
    ticks(2);
    rst = 1'b0;
    ticks(2);
    check("arst_serin", {24'b0, serin}, 8'h00);

`ifdef POKEY_SIO_LOOPBACK_EN
    loop_en = 1'b1;
    txd_low = 0;
    serout = 8'hC3;
    serout_rdy = 1'b1;
    tick();
    serout_rdy = 1'b0;
    wait_rdy(200);
    check("loop_rdy", {31'b0, serin_rdy}, 1);
    check("loop_data", {24'b0, serin}, 8'hC3);
    ticks(10);
    check("loop_txd_idle", txd_low, 0);
    loop_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
